dual_seq_detector: RTL and testbench

DUAL_SEQ_DETECTOR -- requirements
Module: dual_seq_detector

---
 rtl/dual_seq_detector.sv | 63 ++++++
 tb/tb_dual_seq_detector.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dual_seq_detector.sv
// Mealy detector for the overlapping serial patterns "101" and "0110".
// States track the longest history suffix that is a prefix of either pattern.
module dual_seq_detector (
  input  logic din,
  input  logic clk,
  input  logic reset,
  output logic y
);

  // state | meaning
  // IDLE  | no useful history (after reset)
  // S0    | history ends in "0"
  // S1    | history ends in "1" (not "01")
  // S01   | history ends in "01"
  // S10   | history ends in "10"
  // S011  | history ends in "011"
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S01  = 3'd3,
    S10  = 3'd4,
    S011 = 3'd5
  } state_t;

  state_t state_q, state_d;
  logic   y_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    y_d     = 1'b0;
    case (state_q)
      IDLE: state_d = din ? S1 : S0;
      S0:   state_d = din ? S01 : S0;
      S1:   state_d = din ? S1 : S10;
      S01:  state_d = din ? S011 : S10;
      S10: begin
        state_d = din ? S01 : S0;
        y_d     = din;
      end
      S011: begin
        state_d = din ? S1 : S10;
        y_d     = ~din;
      end
      // 3'b110 / 3'b111 recover to IDLE without flagging
      default: begin
        state_d = IDLE;
        y_d     = 1'b0;
      end
    endcase
  end

  assign y = y_d & ~reset;

endmodule

// File: tb/tb_dual_seq_detector.sv
// Scoreboard bench for dual_seq_detector: directed sequences plus random traffic
// checked against a bit-history pattern matcher.
module tb_dual_seq_detector;

  logic din;
  logic clk;
  logic reset;
  logic y;

  int checks;
  int errors;

  bit   exp_q[$];
  bit   hist[$];
  logic stim_valid;
  bit   done;

  dual_seq_detector dut (
    .din  (din),
    .clk  (clk),
    .reset(reset),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: y is set when the bits since reset, with the current bit
  // appended, end in "101" or "0110".
  function automatic bit model_y(input bit d);
    int n;
    bit r;
    n = hist.size();
    r = 1'b0;
    if (n >= 2 && hist[n-2] == 1'b1 && hist[n-1] == 1'b0 && d == 1'b1) r = 1'b1;
    if (n >= 3 && hist[n-3] == 1'b0 && hist[n-2] == 1'b1 && hist[n-1] == 1'b1 && d == 1'b0)
      r = 1'b1;
    return r;
  endfunction

  task automatic apply(input bit r, input bit d);
    @(posedge clk);
    #1;
    reset = r;
    din   = d;
    if (r) begin
      exp_q.push_back(1'b0);
      hist.delete();
    end else begin
      exp_q.push_back(model_y(d));
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    stim_valid = 1'b1;
  endtask

  task automatic check_state(input string name, input logic [2:0] exp);
    @(posedge clk);
    #1;
    stim_valid = 1'b0;
    reset      = 1'b0;
    checks++;
    if (3'(dut.state_q) !== exp) begin
      errors++;
      $display("FAIL %s state got %0d expected %0d", name, 3'(dut.state_q), exp);
    end
  endtask

  task automatic run_seq(input logic [15:0] bits, input int len);
    apply(1'b1, 1'b0);
    for (int i = len - 1; i >= 0; i--) apply(1'b0, bits[i]);
  endtask

  // monitor: y is sampled mid-cycle, after inputs have settled
  initial begin
    bit e;
    forever begin
      @(negedge clk);
      if (stim_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow y got %b expected none", y);
        end else begin
          e = exp_q.pop_front();
          if (y !== e) begin
            errors++;
            $display("FAIL y_check t=%0t din=%b reset=%b got %b expected %b",
                     $time, din, reset, y, e);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    if (!done) begin
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "watchdog");
    end
  end

  initial begin
    logic [15:0] v;
    done       = 1'b0;
    checks     = 0;
    errors     = 0;
    stim_valid = 1'b0;
    reset      = 1'b1;
    din        = 1'b0;

    // reset state
    @(posedge clk);
    check_state("reset_idle", 3'd0);

    // long mixed stream
    v = 16'b0_011011001010110;
    run_seq(v, 15);
    // overlapping "101"
    v = 16'b10101;
    run_seq(v, 5);
    // cross-pattern overlap
    v = 16'b0110110;
    run_seq(v, 7);
    // no match, settle in S1 / S0
    v = 16'b1111;
    run_seq(v, 4);
    check_state("ones_s1", 3'd2);
    v = 16'b0000;
    run_seq(v, 4);
    check_state("zeros_s0", 3'd1);

    // history discard
    v = 16'b011;
    run_seq(v, 3);
    apply(1'b1, 1'b1);
    apply(1'b0, 1'b0);
    check_state("discard_s0", 3'd1);

    // din toggling under reset
    apply(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, i[0]);
      check_state("reset_toggle_idle", 3'd0);
    end

    // random traffic with occasional resets
    apply(1'b1, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #1;
    stim_valid = 1'b0;
    @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
